// File: rtl/scope_capture_pkg.sv
// Shared constants, state encoding and small helpers for the logic-analyser capture block.
package scope_pkg;

    localparam logic [7:0] CMD_ARM   = 8'h61;
    localparam logic [7:0] CMD_FORCE = 8'h74;
    localparam logic [7:0] CMD_ABORT = 8'h78;
    localparam logic [7:0] HDR_BYTE  = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARMED     = 3'd1,
        ST_CAPTURE   = 3'd2,
        ST_SEND_HDR  = 3'd3,
        ST_SEND_DATA = 3'd4,
        ST_TX_WAIT   = 3'd5
    } state_t;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Header byte idx: 0 = sync byte, 1/2 = byte count low/high.
    function automatic logic [7:0] hdr_byte(input logic [1:0] idx, input logic [15:0] nbytes);
        case (idx)
            2'd0:    return HDR_BYTE;
            2'd1:    return nbytes[7:0];
            default: return nbytes[15:8];
        endcase
    endfunction

endpackage

// File: rtl/scope_capture_if.sv
// Serial-link side of the capture block: command bytes in, response bytes out.
interface scope_capture_if;
    logic [7:0] rx_data;
    logic       new_rx_data;
    logic [7:0] tx_data;
    logic       new_tx_data;
    logic       tx_busy;

    modport master (output rx_data, new_rx_data, tx_busy, input tx_data, new_tx_data);
    modport slave  (input rx_data, new_rx_data, tx_busy, output tx_data, new_tx_data);
endinterface

// File: rtl/scope_capture_sample_ram.sv
// Single-port synchronous byte RAM holding packed samples; read data appears one cycle after the address.
module sample_ram #(
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [7:0]    i_wdata,
    output logic [7:0]    o_rdata
);
    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        o_rdata <= r_mem[i_addr];
    end
endmodule

// File: rtl/scope_capture.sv
// One-bit logic-analyser: arm/force over the serial link, capture NUM_SAMPLES pin samples, stream them back.
//   state     | meaning
//   IDLE      | waiting for 'a' (arm) or 't' (forced trigger)
//   ARMED     | waiting for a rising edge on the synchronized pin
//   CAPTURE   | sampling every SAMPLE_DIV cycles, packing 8 samples per RAM byte
//   SEND_HDR  | sending 0xA5 and the byte count (low, high)
//   SEND_DATA | waiting on RAM read latency, then sending the addressed byte
//   TX_WAIT   | one cycle after each strobe before tx_busy is looked at again
module scope_capture
    import scope_pkg::*;
#(
    parameter int SAMPLE_DIV  = 4,
    parameter int NUM_SAMPLES = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            input_pin,
    output logic            busy,
    scope_capture_if.slave  bus
);
    localparam int          NUM_BYTES  = NUM_SAMPLES / 8;
    localparam int          AW         = addr_width(NUM_BYTES);
    localparam logic [7:0]  DIV_RELOAD = 8'(SAMPLE_DIV - 1);
    localparam logic [12:0] LAST_SAMP  = 13'(NUM_SAMPLES - 1);
    localparam logic [15:0] NBYTES16   = 16'(NUM_BYTES);
    localparam logic [15:0] TX_TOTAL   = 16'(NUM_BYTES + 3);

    state_t        r_state;
    logic          r_sync1, r_sync2, r_pin_prev;
    logic          r_busy;
    logic [7:0]    r_tx_data;
    logic          r_tx_strobe;
    logic [7:0]    r_div_cnt;
    logic [12:0]   r_samp_cnt;
    logic [7:0]    r_shift;
    logic [AW-1:0] r_wr_addr;
    logic [AW-1:0] r_ram_addr;
    logic          r_ram_we;
    logic [7:0]    r_ram_wdata;
    logic [15:0]   r_tx_cnt;
    logic          r_rd_valid;

    logic          w_abort;
    logic          w_rise;
    logic [7:0]    w_shift_next;
    logic [7:0]    w_ram_rdata;

    assign w_abort      = bus.new_rx_data && (bus.rx_data == CMD_ABORT);
    assign w_rise       = r_sync2 && !r_pin_prev;
    assign w_shift_next = {r_sync2, r_shift[7:1]};

    assign bus.tx_data     = r_tx_data;
    assign bus.new_tx_data = r_tx_strobe;
    assign busy            = r_busy;

    sample_ram #(.DEPTH(NUM_BYTES), .AW(AW)) u_ram (
        .clk     (clk),
        .i_we    (r_ram_we),
        .i_addr  (r_ram_addr),
        .i_wdata (r_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_pin_prev  <= 1'b0;
            r_busy      <= 1'b0;
            r_tx_data   <= 8'h00;
            r_tx_strobe <= 1'b0;
            r_div_cnt   <= 8'd0;
            r_samp_cnt  <= 13'd0;
            r_shift     <= 8'h00;
            r_wr_addr   <= '0;
            r_ram_addr  <= '0;
            r_ram_we    <= 1'b0;
            r_ram_wdata <= 8'h00;
            r_tx_cnt    <= 16'd0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_sync1     <= input_pin;
            r_sync2     <= r_sync1;
            r_pin_prev  <= r_sync2;
            r_tx_strobe <= 1'b0;
            r_ram_we    <= 1'b0;

            if (w_abort) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.new_rx_data && bus.rx_data == CMD_ARM) begin
                            r_state <= ST_ARMED;
                            r_busy  <= 1'b1;
                        end else if (bus.new_rx_data && bus.rx_data == CMD_FORCE) begin
                            r_state    <= ST_CAPTURE;
                            r_busy     <= 1'b1;
                            r_div_cnt  <= 8'd0;
                            r_samp_cnt <= 13'd0;
                            r_wr_addr  <= '0;
                        end
                    end
                    ST_ARMED: begin
                        // The trigger-cycle pin value is sample 0, so capture starts one sample in.
                        if (w_rise) begin
                            r_state    <= ST_CAPTURE;
                            r_shift    <= w_shift_next;
                            r_samp_cnt <= 13'd1;
                            r_div_cnt  <= DIV_RELOAD;
                            r_wr_addr  <= '0;
                        end
                    end
                    ST_CAPTURE: begin
                        if (r_div_cnt != 8'd0) begin
                            r_div_cnt <= r_div_cnt - 8'd1;
                        end else begin
                            r_div_cnt  <= DIV_RELOAD;
                            r_shift    <= w_shift_next;
                            r_samp_cnt <= r_samp_cnt + 13'd1;
                            if (r_samp_cnt[2:0] == 3'd7) begin
                                r_ram_we    <= 1'b1;
                                r_ram_addr  <= r_wr_addr;
                                r_ram_wdata <= w_shift_next;
                                r_wr_addr   <= r_wr_addr + 1'b1;
                            end
                            if (r_samp_cnt == LAST_SAMP) begin
                                r_state  <= ST_SEND_HDR;
                                r_tx_cnt <= 16'd0;
                            end
                        end
                    end
                    ST_SEND_HDR: begin
                        if (!bus.tx_busy) begin
                            r_tx_data   <= hdr_byte(r_tx_cnt[1:0], NBYTES16);
                            r_tx_strobe <= 1'b1;
                            r_tx_cnt    <= r_tx_cnt + 16'd1;
                            r_state     <= ST_TX_WAIT;
                        end
                    end
                    ST_SEND_DATA: begin
                        // First cycle here only lets the RAM present the addressed byte.
                        if (!r_rd_valid) begin
                            r_rd_valid <= 1'b1;
                        end else if (!bus.tx_busy) begin
                            r_tx_data   <= w_ram_rdata;
                            r_tx_strobe <= 1'b1;
                            r_tx_cnt    <= r_tx_cnt + 16'd1;
                            r_state     <= ST_TX_WAIT;
                        end
                    end
                    ST_TX_WAIT: begin
                        r_rd_valid <= 1'b0;
                        if (r_tx_cnt < 16'd3) begin
                            r_state <= ST_SEND_HDR;
                        end else if (r_tx_cnt < TX_TOTAL) begin
                            r_state    <= ST_SEND_DATA;
                            r_ram_addr <= AW'(r_tx_cnt - 16'd3);
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/scope_capture.md
SCOPE_CAPTURE -- requirements
Module: scope_capture

Interface
REQ-001 Parameter SAMPLE_DIV, default 4: clock cycles between captured samples; legal range 1..255.
REQ-002 Parameter NUM_SAMPLES, default 1024: samples per capture; a multiple of 8, max 4096.
REQ-003 Port clk  input  1: 50 MHz system clock; all logic rises on clk.
REQ-004 Port rst_n  input  1: reset, synchronous, active-low.
REQ-005 Port input_pin  input  1: asynchronous probed signal.
REQ-006 Port rx_data  input  8: command byte from the AVR serial link.
REQ-007 Port new_rx_data  input  1: one-cycle strobe qualifying rx_data.
REQ-008 Port tx_data  output  8: byte to the AVR serial link.
REQ-009 Port new_tx_data  output  1: one-cycle strobe qualifying tx_data.
REQ-010 Port tx_busy  input  1: serial transmitter busy; no strobe while high.
REQ-011 Port busy  output  1: high in every state except IDLE.

Function
REQ-012 input_pin SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value, 2-cycle latency.
REQ-013 States: IDLE, ARMED, CAPTURE, SEND_HDR, SEND_DATA, TX_WAIT.
REQ-014 IDLE + rx byte 0x61 ('a') -> ARMED; IDLE + rx byte 0x74 ('t') -> CAPTURE immediately (forced trigger).
REQ-015 ARMED: a rising edge of the synchronized pin (previous 0, current 1) -> CAPTURE; the trigger-cycle value is sample 0.
REQ-016 A forced trigger takes sample 0 in the cycle after the command strobe.
REQ-017 CAPTURE: one sample every SAMPLE_DIV cycles after sample 0, exactly NUM_SAMPLES samples.
REQ-018 Packing: 8 samples per byte, earliest sample in bit 0; byte k holds samples 8k..8k+7; written to RAM address k once complete.
REQ-019 After the last byte is written -> SEND_HDR.
REQ-020 SEND_HDR: emit 0xA5, then the byte count NUM_SAMPLES/8 as two bytes, low byte first.
REQ-021 SEND_DATA: emit RAM bytes from address 0 upward; after the last byte -> IDLE.
REQ-022 Handshake: pulse new_tx_data for exactly one cycle only when tx_busy is low; then enter TX_WAIT for one cycle, ignoring tx_busy, before sampling it again.
REQ-023 tx_data SHALL be stable from the strobe cycle until the next strobe.
REQ-024 rx byte 0x78 ('x') in any state -> IDLE next cycle; no further tx strobes; a partial capture is discarded.
REQ-025 Any other rx byte, or 'a'/'t' outside IDLE, SHALL be ignored.
REQ-026 new_rx_data coincident with a trigger edge in ARMED: an 'x' abort wins; otherwise the trigger is taken.
REQ-027 The sample-divider counter and RAM address SHALL reset to 0 on entry to CAPTURE; the address counter does not wrap during a capture.

Reset
REQ-028 rst_n low at a clk edge -> state IDLE, tx_data 0x00, new_tx_data 0, busy 0, counters 0, synchronizer flops 0.
REQ-029 Reset mid-capture or mid-transmit SHALL abort without any further strobe; RAM contents are not cleared.
REQ-030 The first command is accepted in the cycle after rst_n returns high.

Structure
REQ-031 Shared package scope_pkg holds CMD_ARM 0x61, CMD_FORCE 0x74, CMD_ABORT 0x78, HDR_BYTE 0xA5 and the state encoding.
REQ-032 One sub-module, sample_ram: single-port synchronous byte RAM, depth NUM_SAMPLES/8, 1-cycle read latency; the FSM accounts for this latency before a data strobe.

Verification
REQ-033 'a', then pin held 0 for 100 cycles, then raised to 1 and held -> 0xA5, 0x80, 0x00, then 128 bytes of 0xFF.
REQ-034 't' with a 2-sample-period square wave (SAMPLE_DIV=4: pin toggles every 4 cycles, aligned to sample 0 = 1) -> every data byte 0x55.
REQ-035 tx_busy held high for 10 cycles after each strobe -> no strobe while busy, strobes spaced at least 2 cycles apart, all 131 bytes delivered in order.
REQ-036 'x' after 300 samples, then 'a' -> busy drops the next cycle, no bytes emitted, and re-arm works.
REQ-037 rst_n pulled low for 1 cycle during SEND_DATA -> new_tx_data 0 from that edge on, state IDLE, busy 0.
REQ-038 'a' then a 1-cycle pin glitch high -> trigger taken, sample 0 = 1, sample 1 = 0, so byte 0 bit 0 = 1 and bit 1 = 0.
